spi_slave: RTL and testbench

- SPI Mode 0 (CPOL=0, CPHA=0) slave/responder, full duplex, operating in the system clock domain.
- Receives MSB-first words on mosi and presents each as a parallel word with a one-cycle valid strobe.
- Simultaneously shifts a host-supplied response word out on miso.
- Serves as the peripheral-side counterpart of the team's SPI master for loopback, bring-up and on-chip peripheral emulation.

---
 rtl/spi_slave_if.sv | 48 ++++
 rtl/spi_slave.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Pin- and host-side signal bundle of the SPI Mode 0 responder.
// The slave modport is the responder's view; the master modport is the driving side.
interface spi_slave_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             mosi;
    logic             cs_n;
    logic             miso;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic             tx_underrun;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  sclk,
        input  mosi,
        input  cs_n,
        input  tx_data,
        input  tx_load,
        output miso,
        output rx_data,
        output rx_valid,
        output tx_ready,
        output tx_underrun,
        output frame_err,
        output busy
    );

    modport master (
        output sclk,
        output mosi,
        output cs_n,
        output tx_data,
        output tx_load,
        input  miso,
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        input  tx_underrun,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI Mode 0 responder running entirely in the clk domain: oversampled pins,
// MSB-first receive with a one-cycle strobe, and a single-entry transmit buffer.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    // Idle levels of the pins, ordered {cs_n, mosi, sclk}
    localparam logic [2:0] SYNC_RST = 3'b100;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [2:0] pin_raw;
    logic [2:0] pin_sync;

    assign pin_raw = {bus.cs_n, bus.mosi, bus.sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_q <= {SYNC_STAGES{SYNC_RST[gi]}};
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], pin_raw[gi]};
                end
            end

            assign pin_sync[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    logic                 sclk_prev_q;
    logic                 cs_prev_q;
    logic [SYNC_STAGES:0] settle_q;
    logic                 sclk_rise_q;
    logic                 sclk_fall_q;
    logic                 cs_rise_q;
    logic                 cs_fall_q;
    logic                 mosi_q;
    logic                 edge_en;

    // Edges are suppressed until the chains hold real pin values, so a cs_n
    // that is already low when reset releases never looks like a new frame.
    assign edge_en = settle_q[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_prev_q <= pin_sync[0];
            cs_prev_q   <= pin_sync[2];
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            sclk_rise_q <= edge_en &  pin_sync[0] & ~sclk_prev_q;
            sclk_fall_q <= edge_en & ~pin_sync[0] &  sclk_prev_q;
            cs_rise_q   <= edge_en &  pin_sync[2] & ~cs_prev_q;
            cs_fall_q   <= edge_en & ~pin_sync[2] &  cs_prev_q;
            mosi_q      <= pin_sync[1];
        end
    end

    state_t           state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             rx_pending_q;
    logic             word_done_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-1:0] tx_buf_q;
    logic             tx_ready_q;
    logic             tx_underrun_q;
    logic             frame_err_q;
    logic             busy_q;

    logic             word_start_d;
    logic [WIDTH-1:0] rx_word_d;
    logic [WIDTH-1:0] tx_next_d;

    // A cs_n rise in the same cycle as an sclk fall blocks the next word start.
    assign word_start_d = (state_q == IDLE) ? cs_fall_q
                                            : (!cs_rise_q && sclk_fall_q && word_done_q);
    assign rx_word_d    = {rx_shift_q[WIDTH-2:0], mosi_q};
    assign tx_next_d    = tx_ready_q ? '0 : tx_buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_pending_q  <= 1'b0;
            word_done_q   <= 1'b0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;

            // A completed word is delivered even if the frame closes right after it.
            if (rx_pending_q) begin
                rx_data_q    <= rx_shift_q;
                rx_valid_q   <= 1'b1;
                rx_pending_q <= 1'b0;
            end

            // A load coinciding with an underrunning word start is kept for the next word.
            if (bus.tx_load && tx_ready_q) begin
                tx_buf_q   <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end else if (word_start_d && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end

            if (word_start_d) begin
                tx_shift_q <= tx_next_d;
                if (tx_ready_q) begin
                    tx_underrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall_q) begin
                        state_q     <= ACTIVE;
                        busy_q      <= 1'b1;
                        bit_cnt_q   <= '0;
                        word_done_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_q) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        tx_shift_q  <= '0;
                        bit_cnt_q   <= '0;
                        word_done_q <= 1'b0;
                        if (bit_cnt_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise_q) begin
                        rx_shift_q <= rx_word_d;
                        if (bit_cnt_q == CW'(WIDTH - 1)) begin
                            bit_cnt_q    <= '0;
                            word_done_q  <= 1'b1;
                            rx_pending_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall_q) begin
                        if (word_done_q) begin
                            word_done_q <= 1'b0;
                        end else begin
                            tx_shift_q <= tx_shift_q << 1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso        = tx_shift_q[WIDTH-1];
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bus-level master drives frames at clk/8 while
// a queue/buffer model predicts every received word and every transmitted word.
module tb_spi_slave;
    localparam int W  = 8;
    localparam int SS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(W)) sif ();

    spi_slave #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] last_rx  = 8'h00;
    logic       mdl_full = 1'b0;
    logic [7:0] mdl_buf  = 8'h00;
    int         uf_exp   = 0;
    int         uf_seen  = 0;
    int         fe_seen  = 0;
    logic       prev_valid = 1'b0;
    longint     rise_t   = 0;
    longint     rv_t     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every cycle: received words must come out in order, one strobe each,
    // rx_data must otherwise hold, and miso must be quiet outside a frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.rx_valid) begin
                rv_t = $time;
                check("rx_single_pulse", 32'(prev_valid), 32'(0));
                check("rx_expected", 32'(exp_rx_q.size() > 0), 32'(1));
                if (exp_rx_q.size() > 0) begin
                    last_rx = exp_rx_q.pop_front();
                    check("rx_data", 32'(sif.rx_data), 32'(last_rx));
                end
            end else begin
                check("rx_data_hold", 32'(sif.rx_data), 32'(last_rx));
            end
            if (!sif.busy) begin
                check("miso_idle", 32'(sif.miso), 32'(0));
            end
            if (sif.tx_underrun) uf_seen++;
            if (sif.frame_err)   fe_seen++;
            prev_valid = sif.rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Word start in the model: the buffered word goes out, or zeros with an underrun.
    function automatic logic [7:0] mdl_word_start();
        logic [7:0] w;
        if (mdl_full) begin
            w        = mdl_buf;
            mdl_full = 1'b0;
        end else begin
            w = 8'h00;
            uf_exp++;
        end
        return w;
    endfunction

    task automatic load(input logic [7:0] d);
        sif.tx_data = d;
        sif.tx_load = 1'b1;
        tick(1);
        sif.tx_load = 1'b0;
        if (!mdl_full) begin
            mdl_full = 1'b1;
            mdl_buf  = d;
        end
        tick(1);
        check("tx_ready_after_load", 32'(sif.tx_ready), 32'(!mdl_full));
    endtask

    task automatic start_frame(output logic [7:0] first_word);
        first_word = mdl_word_start();
        sif.cs_n   = 1'b0;
        tick(8);
        check("busy_in_frame", 32'(sif.busy), 32'(1));
        check("tx_ready_after_start", 32'(sif.tx_ready), 32'(!mdl_full));
    endtask

    // sclk returns low together with cs_n rising, so no trailing word start occurs.
    task automatic end_frame();
        sif.sclk = 1'b0;
        sif.cs_n = 1'b1;
        tick(8);
        check("busy_after_frame", 32'(sif.busy), 32'(0));
    endtask

    task automatic send_word(input logic [7:0] tx, input bit last, input int nbits,
                             output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sif.mosi = tx[7-i];
            tick(4);
            sif.sclk   = 1'b1;
            rise_t     = $time;
            got[7-i]   = sif.miso;
            tick(4);
            if (!(last && i == nbits - 1)) sif.sclk = 1'b0;
        end
        if (nbits == 8) exp_rx_q.push_back(tx);
    endtask

    initial begin
        logic [7:0] w0, w1, g0, g1;
        int uf0, fe0;

        sif.sclk    = 1'b0;
        sif.mosi    = 1'b0;
        sif.cs_n    = 1'b1;
        sif.tx_load = 1'b0;
        sif.tx_data = 8'h00;
        tick(3);
        check("rst_rx_data",  32'(sif.rx_data),     32'(0));
        check("rst_rx_valid", 32'(sif.rx_valid),    32'(0));
        check("rst_tx_ready", 32'(sif.tx_ready),    32'(1));
        check("rst_busy",     32'(sif.busy),        32'(0));
        check("rst_miso",     32'(sif.miso),        32'(0));
        check("rst_underrun", 32'(sif.tx_underrun), 32'(0));
        check("rst_frame_err",32'(sif.frame_err),   32'(0));
        rst_n = 1'b1;
        tick(6);

        // Single word with a buffered response
        load(8'hA5);
        uf0 = uf_seen;
        start_frame(w0);
        send_word(8'h3C, 1'b1, 8, g0);
        end_frame();
        check("t1_miso_model", 32'(g0), 32'(w0));
        check("t1_miso",       32'(g0), 32'(8'hA5));
        check("t1_rx",         32'(sif.rx_data), 32'(8'h3C));
        check("t1_latency",    32'(rv_t - rise_t), 32'((SS + 3) * 10));
        check("t1_no_underrun",32'(uf_seen - uf0), 32'(0));

        // Empty buffer: zeros go out and one underrun is flagged
        uf0 = uf_seen;
        start_frame(w0);
        send_word(8'hFF, 1'b1, 8, g0);
        end_frame();
        check("t2_miso_model", 32'(g0), 32'(w0));
        check("t2_miso",       32'(g0), 32'(8'h00));
        check("t2_rx",         32'(sif.rx_data), 32'(8'hFF));
        check("t2_underrun",   32'(uf_seen - uf0), 32'(1));

        // Back-to-back words in one frame, buffer refilled between them
        uf0 = uf_seen;
        load(8'h55);
        start_frame(w0);
        load(8'hAA);
        send_word(8'h12, 1'b0, 8, g0);
        w1 = mdl_word_start();
        send_word(8'h34, 1'b1, 8, g1);
        end_frame();
        check("t3_miso0_model", 32'(g0), 32'(w0));
        check("t3_miso1_model", 32'(g1), 32'(w1));
        check("t3_miso0",       32'(g0), 32'(8'h55));
        check("t3_miso1",       32'(g1), 32'(8'hAA));
        check("t3_rx",          32'(sif.rx_data), 32'(8'h34));
        check("t3_no_underrun", 32'(uf_seen - uf0), 32'(0));
        check("t3_tx_ready",    32'(sif.tx_ready), 32'(!mdl_full));

        // Frame aborted after 5 bits, then a clean frame
        fe0 = fe_seen;
        start_frame(w0);
        send_word(8'hF0, 1'b1, 5, g0);
        end_frame();
        check("t4_frame_err", 32'(fe_seen - fe0), 32'(1));
        check("t4_rx_hold",   32'(sif.rx_data), 32'(8'h34));
        start_frame(w0);
        send_word(8'h81, 1'b1, 8, g0);
        end_frame();
        check("t4_rx",        32'(sif.rx_data), 32'(8'h81));
        check("t4_fe_once",   32'(fe_seen - fe0), 32'(1));

        // Reset in the middle of a frame, cs_n still low at release
        start_frame(w0);
        send_word(8'h5A, 1'b0, 3, g0);
        rst_n = 1'b0;
        #1;
        check("t5_rx_data",   32'(sif.rx_data),     32'(0));
        check("t5_rx_valid",  32'(sif.rx_valid),    32'(0));
        check("t5_tx_ready",  32'(sif.tx_ready),    32'(1));
        check("t5_busy",      32'(sif.busy),        32'(0));
        check("t5_miso",      32'(sif.miso),        32'(0));
        check("t5_underrun",  32'(sif.tx_underrun), 32'(0));
        check("t5_frame_err", 32'(sif.frame_err),   32'(0));
        mdl_full = 1'b0;
        last_rx  = 8'h00;
        exp_rx_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("t5_no_frame",  32'(sif.busy), 32'(0));
        fe0 = fe_seen;
        sif.cs_n = 1'b1;
        tick(8);
        check("t5_no_fe",     32'(fe_seen - fe0), 32'(0));
        check("t5_uf_model",  32'(uf_seen), 32'(uf_exp));
        start_frame(w0);
        send_word(8'hC3, 1'b1, 8, g0);
        end_frame();
        check("t5_rx",        32'(sif.rx_data), 32'(8'hC3));

        // Load while the buffer is full is ignored
        load(8'h66);
        load(8'h99);
        start_frame(w0);
        send_word(8'h0F, 1'b1, 8, g0);
        end_frame();
        check("t6_miso_model", 32'(g0), 32'(w0));
        check("t6_miso",       32'(g0), 32'(8'h66));
        check("t6_rx",         32'(sif.rx_data), 32'(8'h0F));

        tick(4);
        check("rx_all_delivered", 32'(exp_rx_q.size()), 32'(0));
        check("underrun_total",   32'(uf_seen), 32'(uf_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
